serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 119 +++++++++++
 1 files changed

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Brief    : Bit-serial ripple adder, LSB first, one bit per cycle; optional
//            signed-overflow flag built only when SERIAL_ADDER_OVF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             OVF,
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W  = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_c;
    logic             w_sum_bit;
    logic             w_cout;
    logic             w_last;

    assign w_sum_bit = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_cout    = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    assign w_last    = (r_state == ST_RUN) && (r_cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_RUN;
            ST_RUN:  if (r_cnt == C_LAST) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // r_a doubles as the result shift register: sum bits enter at the MSB
    // as operand bits leave at the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_c     <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_a     <= A;
                r_b     <= B;
                r_carry <= CIN;
                r_cnt   <= '0;
            end else if (r_state == ST_RUN) begin
                r_a     <= {w_sum_bit, r_a[WIDTH-1:1]};
                r_b     <= r_b >> 1;
                r_carry <= w_cout;
                r_cnt   <= r_cnt + CNT_W'(1);
            end
            if (w_last) begin
                r_s <= {w_sum_bit, r_a[WIDTH-1:1]};
                r_c <= w_cout;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // On the final RUN cycle r_carry is the carry into the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_carry ^ w_cout;
        end
    end

    assign OVF = r_ovf;
`else
    assign OVF = 1'b0;
`endif

    assign S    = r_s;
    assign C    = r_c;
    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);

endmodule
`default_nettype wire
